// File: rtl/int_sched.sv
// Machine-level interrupt scheduler: latches CLINT pulses, masks with mie/mstatus.MIE
// and presents one prioritised cause at a time to the core over REQ/ACK.
module int_sched #(
  parameter int unsigned MAX_WAIT    = 32'd256,
  parameter int unsigned COOL_CYCLES = 32'd2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLINT_INT_EN,
  input  logic [3:0]  CLINT_INT_CODE,
  input  logic        EXT_INT,
  input  logic        MSTATUS_MIE,
  input  logic [31:0] MIE,
  input  logic        INT_ACK,
  output logic        INT_REQ,
  output logic [3:0]  INT_CAUSE,
  output logic [31:0] MIP
);

  localparam int unsigned CAUSE_W = 4;
  localparam int unsigned CNT_W   = 32;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE = 4'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_SW   = 4'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_TM   = 4'd7;
  localparam logic [CAUSE_W-1:0] CAUSE_EXT  = 4'd11;

  // Terminal counts; a cool-down of zero is treated as one cycle.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 32'd1);
  localparam logic [CNT_W-1:0] COOL_LAST =
    (COOL_CYCLES > 32'd1) ? CNT_W'(COOL_CYCLES - 32'd1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_COOL = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 pend_sw_q, pend_sw_d;
  logic                 pend_tm_q, pend_tm_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]     cool_cnt_q, cool_cnt_d;
  logic                 int_req_q, int_req_d;
  logic [CAUSE_W-1:0]   int_cause_q, int_cause_d;

  logic                 en_ext_c, en_sw_c, en_tm_c, any_en_c;
  logic [CAUSE_W-1:0]   top_cause_c;
  logic                 cause_en_c;
  logic                 set_sw_c, set_tm_c, clr_sw_c;
  logic                 ack_c, timeout_c;

  // Only mie bits 3, 7 and 11 carry meaning here.
  logic mie_unused;
  assign mie_unused = ^{MIE[31:12], MIE[10:8], MIE[6:4], MIE[2:0]};

  // Masked enable vector and fixed priority MEI > MSI > MTI.
  always_comb begin
    en_ext_c    = MSTATUS_MIE & EXT_INT   & MIE[11];
    en_sw_c     = MSTATUS_MIE & pend_sw_q & MIE[3];
    en_tm_c     = MSTATUS_MIE & pend_tm_q & MIE[7];
    any_en_c    = en_ext_c | en_sw_c | en_tm_c;
    top_cause_c = CAUSE_NONE;
    if (en_ext_c) begin
      top_cause_c = CAUSE_EXT;
    end else if (en_sw_c) begin
      top_cause_c = CAUSE_SW;
    end else if (en_tm_c) begin
      top_cause_c = CAUSE_TM;
    end
  end

  // Enable of the cause currently held in REQ.
  always_comb begin
    cause_en_c = 1'b0;
    case (int_cause_q)
      CAUSE_EXT: cause_en_c = en_ext_c;
      CAUSE_SW:  cause_en_c = en_sw_c;
      CAUSE_TM:  cause_en_c = en_tm_c;
      default:   cause_en_c = 1'b0;
    endcase
  end

  always_comb begin
    set_sw_c  = CLINT_INT_EN  && (CLINT_INT_CODE == CAUSE_SW);
    set_tm_c  = CLINT_INT_EN  && (CLINT_INT_CODE == CAUSE_TM);
    clr_sw_c  = !CLINT_INT_EN && (CLINT_INT_CODE == CAUSE_SW);
    ack_c     = (state_q == ST_REQ) && INT_ACK;
    timeout_c = (MAX_WAIT != 32'd0) && (wait_cnt_q == WAIT_LAST);
  end

  // Pending latches: clears are applied first so a same-cycle set wins.
  always_comb begin
    pend_sw_d = pend_sw_q;
    pend_tm_d = pend_tm_q;
    if (ack_c && (int_cause_q == CAUSE_SW)) begin
      pend_sw_d = 1'b0;
    end
    if (ack_c && (int_cause_q == CAUSE_TM)) begin
      pend_tm_d = 1'b0;
    end
    if (clr_sw_c) begin
      pend_sw_d = 1'b0;
    end
    if (set_sw_c) begin
      pend_sw_d = 1'b1;
    end
    if (set_tm_c) begin
      pend_tm_d = 1'b1;
    end
  end

  // Request FSM next state and registered outputs.
  always_comb begin
    state_d     = state_q;
    int_req_d   = int_req_q;
    int_cause_d = int_cause_q;
    wait_cnt_d  = wait_cnt_q;
    cool_cnt_d  = cool_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_en_c) begin
          state_d     = ST_REQ;
          int_req_d   = 1'b1;
          int_cause_d = top_cause_c;
          wait_cnt_d  = '0;
        end
      end
      ST_REQ: begin
        if (ack_c) begin
          state_d     = ST_COOL;
          int_req_d   = 1'b0;
          int_cause_d = CAUSE_NONE;
          cool_cnt_d  = '0;
        end else if (!cause_en_c || timeout_c) begin
          state_d     = ST_IDLE;
          int_req_d   = 1'b0;
          int_cause_d = CAUSE_NONE;
        end else if (MAX_WAIT != 32'd0) begin
          wait_cnt_d  = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_COOL: begin
        if (cool_cnt_q >= COOL_LAST) begin
          state_d    = ST_IDLE;
        end else begin
          cool_cnt_d = cool_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        int_req_d   = 1'b0;
        int_cause_d = CAUSE_NONE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      pend_sw_q   <= 1'b0;
      pend_tm_q   <= 1'b0;
      wait_cnt_q  <= '0;
      cool_cnt_q  <= '0;
      int_req_q   <= 1'b0;
      int_cause_q <= CAUSE_NONE;
    end else begin
      state_q     <= state_d;
      pend_sw_q   <= pend_sw_d;
      pend_tm_q   <= pend_tm_d;
      wait_cnt_q  <= wait_cnt_d;
      cool_cnt_q  <= cool_cnt_d;
      int_req_q   <= int_req_d;
      int_cause_q <= int_cause_d;
    end
  end

  assign INT_REQ   = int_req_q;
  assign INT_CAUSE = int_cause_q;

  // mip read value: latched software/timer pending plus the live external line.
  always_comb begin
    MIP     = '0;
    MIP[3]  = pend_sw_q;
    MIP[7]  = pend_tm_q;
    MIP[11] = EXT_INT;
  end

endmodule

// File: tb/tb_int_sched.sv
// Directed-vector bench for int_sched: each cycle's expected outputs go into a
// scoreboard queue and a negedge monitor pops and compares them.
module tb_int_sched;

  localparam int unsigned MAX_WAIT    = 4;
  localparam int unsigned COOL_CYCLES = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CLINT_INT_EN;
  logic [3:0]  CLINT_INT_CODE;
  logic        EXT_INT;
  logic        MSTATUS_MIE;
  logic [31:0] MIE;
  logic        INT_ACK;
  logic        INT_REQ;
  logic [3:0]  INT_CAUSE;
  logic [31:0] MIP;

  typedef struct {
    int          idx;
    logic        req;
    logic [3:0]  cause;
    logic [31:0] mip;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   vec_idx   = 0;
  bit   stim_done = 1'b0;

  int_sched #(
    .MAX_WAIT    (MAX_WAIT),
    .COOL_CYCLES (COOL_CYCLES)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .CLINT_INT_EN   (CLINT_INT_EN),
    .CLINT_INT_CODE (CLINT_INT_CODE),
    .EXT_INT        (EXT_INT),
    .MSTATUS_MIE    (MSTATUS_MIE),
    .MIE            (MIE),
    .INT_ACK        (INT_ACK),
    .INT_REQ        (INT_REQ),
    .INT_CAUSE      (INT_CAUSE),
    .MIP            (MIP)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input int rst, input int en, input int code, input int ext,
                      input int mm, input logic [31:0] mie, input int ack,
                      input int ereq, input int ecause, input logic [31:0] emip);
    exp_t e;
    @(posedge CLK);
    #1;
    RST            = 1'(rst);
    CLINT_INT_EN   = 1'(en);
    CLINT_INT_CODE = 4'(code);
    EXT_INT        = 1'(ext);
    MSTATUS_MIE    = 1'(mm);
    MIE            = mie;
    INT_ACK        = 1'(ack);
    e.idx   = vec_idx;
    e.req   = 1'(ereq);
    e.cause = 4'(ecause);
    e.mip   = emip;
    exp_q.push_back(e);
    vec_idx++;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @vec%0d: got 0x%0h, want 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin : stimulus
    RST = 1'b1; CLINT_INT_EN = 1'b0; CLINT_INT_CODE = 4'd0; EXT_INT = 1'b0;
    MSTATUS_MIE = 1'b0; MIE = 32'h0; INT_ACK = 1'b0;
    repeat (2) @(posedge CLK);
    //    rst en cd ex mm mie        ak  req cs  mip
    // reset state, MIP bit 11 follows EXT_INT even in reset
    step(1, 0, 0, 0, 0, 32'h000, 0,  0, 0,  32'h000);
    step(1, 0, 0, 1, 0, 32'h000, 0,  0, 0,  32'h800);
    step(0, 0, 0, 0, 0, 32'h000, 0,  0, 0,  32'h000);
    // timer pulse -> MIP next cycle, REQ two cycles later, ACK, cool-down
    step(0, 1, 7, 0, 1, 32'h080, 0,  0, 0,  32'h000);
    step(0, 0, 0, 0, 1, 32'h080, 0,  0, 0,  32'h080);
    step(0, 0, 0, 0, 1, 32'h080, 0,  1, 7,  32'h080);
    step(0, 0, 0, 0, 1, 32'h080, 0,  1, 7,  32'h080);
    step(0, 0, 0, 0, 1, 32'h080, 1,  1, 7,  32'h080);
    step(0, 0, 0, 0, 1, 32'h080, 0,  0, 0,  32'h000);
    step(0, 0, 0, 0, 1, 32'h080, 0,  0, 0,  32'h000);
    step(0, 0, 0, 0, 1, 32'h080, 0,  0, 0,  32'h000);
    step(0, 0, 0, 0, 1, 32'h080, 0,  0, 0,  32'h000);
    // priority: all three pending, then enable globally
    step(0, 1, 3, 0, 0, 32'h888, 0,  0, 0,  32'h000);
    step(0, 1, 7, 1, 0, 32'h888, 0,  0, 0,  32'h808);
    step(0, 0, 0, 1, 0, 32'h888, 0,  0, 0,  32'h888);
    step(0, 0, 0, 1, 1, 32'h888, 0,  0, 0,  32'h888);
    step(0, 0, 0, 1, 1, 32'h888, 1,  1, 11, 32'h888);
    step(0, 0, 0, 0, 1, 32'h888, 0,  0, 0,  32'h088);
    step(0, 0, 0, 0, 1, 32'h888, 0,  0, 0,  32'h088);
    step(0, 0, 0, 0, 1, 32'h888, 0,  0, 0,  32'h088);
    step(0, 0, 0, 0, 1, 32'h888, 1,  1, 3,  32'h088);
    step(0, 0, 0, 0, 1, 32'h888, 0,  0, 0,  32'h080);
    step(0, 0, 0, 0, 1, 32'h888, 0,  0, 0,  32'h080);
    step(0, 0, 0, 0, 1, 32'h888, 0,  0, 0,  32'h080);
    step(0, 0, 0, 0, 1, 32'h888, 1,  1, 7,  32'h080);
    step(0, 0, 0, 0, 1, 32'h888, 0,  0, 0,  32'h000);
    step(0, 0, 0, 0, 1, 32'h888, 0,  0, 0,  32'h000);
    step(0, 0, 0, 0, 1, 32'h888, 0,  0, 0,  32'h000);
    // software set then msip=0 clear, globally masked; unknown code ignored
    step(0, 1, 3, 0, 0, 32'h888, 0,  0, 0,  32'h000);
    step(0, 0, 3, 0, 0, 32'h888, 0,  0, 0,  32'h008);
    step(0, 0, 0, 0, 0, 32'h888, 0,  0, 0,  32'h000);
    step(0, 1, 5, 0, 0, 32'h888, 0,  0, 0,  32'h000);
    // masking withdraw and re-request
    step(0, 1, 7, 0, 1, 32'h080, 0,  0, 0,  32'h000);
    step(0, 0, 0, 0, 1, 32'h080, 0,  0, 0,  32'h080);
    step(0, 0, 0, 0, 1, 32'h080, 0,  1, 7,  32'h080);
    step(0, 0, 0, 0, 0, 32'h080, 0,  1, 7,  32'h080);
    step(0, 0, 0, 0, 0, 32'h080, 0,  0, 0,  32'h080);
    step(0, 0, 0, 0, 1, 32'h080, 0,  0, 0,  32'h080);
    // timeout after 4 REQ cycles (EN=0 code 7 must not clear), ACK in IDLE ignored
    step(0, 0, 7, 0, 1, 32'h080, 0,  1, 7,  32'h080);
    step(0, 0, 0, 0, 1, 32'h080, 0,  1, 7,  32'h080);
    step(0, 0, 0, 0, 1, 32'h080, 0,  1, 7,  32'h080);
    step(0, 0, 0, 0, 1, 32'h080, 0,  1, 7,  32'h080);
    step(0, 0, 0, 0, 1, 32'h080, 1,  0, 0,  32'h080);
    // ACK and new timer pulse together: pending survives, re-request after cool-down
    step(0, 1, 7, 0, 1, 32'h080, 1,  1, 7,  32'h080);
    step(0, 0, 0, 0, 1, 32'h080, 0,  0, 0,  32'h080);
    step(0, 0, 0, 0, 1, 32'h080, 0,  0, 0,  32'h080);
    step(0, 0, 0, 0, 1, 32'h080, 0,  0, 0,  32'h080);
    // reset mid-REQ drops request and pending
    step(1, 0, 0, 0, 1, 32'h080, 0,  1, 7,  32'h080);
    step(0, 0, 0, 0, 1, 32'h080, 0,  0, 0,  32'h000);
    step(0, 0, 0, 0, 1, 32'h080, 0,  0, 0,  32'h000);
    // external request withdrawn when EXT_INT falls
    step(0, 0, 0, 1, 1, 32'h800, 0,  0, 0,  32'h800);
    step(0, 0, 0, 0, 1, 32'h800, 0,  1, 11, 32'h000);
    step(0, 0, 0, 0, 1, 32'h800, 0,  0, 0,  32'h000);
    step(0, 0, 0, 0, 1, 32'h800, 0,  0, 0,  32'h000);
    stim_done = 1'b1;
  end

  initial begin : monitor
    exp_t e;
    int   guard;
    guard = 0;
    while (!(stim_done && exp_q.size() == 0) && guard < 200) begin
      @(negedge CLK);
      guard++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("INT_REQ",   e.idx, 32'(INT_REQ),   32'(e.req));
        check("INT_CAUSE", e.idx, 32'(INT_CAUSE), 32'(e.cause));
        check("MIP",       e.idx, MIP,            e.mip);
      end
    end
    if (!stim_done || exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/int_sched.md
Name: int_sched

Overview:
- Machine-level interrupt scheduler between the CLINT/external interrupt sources and the core's trap logic.
- Converts the CLINT's single-cycle INT_EN/INT_CODE pulses into latched pending bits and merges them with a level-sensitive external interrupt line.
- Applies the mie/mstatus.MIE masks and presents one prioritised cause at a time to the core over a REQ/ACK handshake.
- Also drives the mip read value for the CSR unit.

Parameters:
- MAX_WAIT, 32'd256: cycles INT_REQ may stay unacknowledged before it is withdrawn; 0 disables the timeout.
- COOL_CYCLES, 32'd2: idle gap after an ACK before re-arbitration, so CSR updates made by the trap handler propagate; minimum 1.

Ports:
- CLK  in  1  clock; all logic is on the posedge.
- RST  in  1  synchronous, active-high reset.
- CLINT_INT_EN  in  1  CLINT interrupt pulse.
- CLINT_INT_CODE  in  4  CLINT cause code: 3 = software, 7 = timer, 0 = none.
- EXT_INT  in  1  external interrupt, level-sensitive (MEIP).
- MSTATUS_MIE  in  1  global machine interrupt enable.
- MIE  in  32  mie CSR; only bits 3, 7 and 11 are used.
- INT_ACK  in  1  core accepts the presented cause (trap taken).
- INT_REQ  out  1  interrupt request to the core.
- INT_CAUSE  out  4  cause being requested: 3, 7 or 11.
- MIP  out  32  mip value: bit 3 = pend_sw, bit 7 = pend_tm, bit 11 = EXT_INT; all other bits 0.

Behaviour:
- Reset: INT_REQ=0, INT_CAUSE=0, pend_sw=0, pend_tm=0, wait/cool counters=0, state=IDLE. MIP shows only bit 11 = EXT_INT.
- Pending set/clear, sampled each posedge:
  - CLINT_INT_EN=1 and code 3: set pend_sw.
  - CLINT_INT_EN=1 and code 7: set pend_tm.
  - CLINT_INT_EN=0 and code 3 (software write of msip=0): clear pend_sw.
  - Any other code: ignored.
  - An ACK in REQ clears the pending bit matching INT_CAUSE. Cause 11 has no latch; the external source deasserts EXT_INT itself.
  - Set and ACK-clear of the same bit in the same cycle: set wins.
- Enabled vector: en_ext = EXT_INT & MIE[11]; en_sw = pend_sw & MIE[3]; en_tm = pend_tm & MIE[7]. All three are gated by MSTATUS_MIE.
- Priority: 11 > 3 > 7 (RISC-V MEI > MSI > MTI).
- MIP is combinational from the pending registers. A CLINT pulse in cycle N is visible on MIP in N+1.
- State IDLE:
  - If any enabled bit is set, latch the highest-priority cause into INT_CAUSE, set INT_REQ=1, go to REQ.
  - INT_REQ rises the cycle after the enable condition is seen. CLINT pulse in N → INT_REQ=1 in N+2.
- State REQ:
  - INT_CAUSE is held stable; no preemption by a later, higher-priority cause.
  - On INT_ACK=1: clear the matching pending bit, INT_REQ=0 and INT_CAUSE=0 next cycle, go to COOL.
  - Withdraw without ACK if the enable for the latched cause drops (MSTATUS_MIE=0, MIE bit cleared, or EXT_INT low for cause 11): INT_REQ=0 next cycle, go to IDLE, pending bits unchanged.
  - Timeout: if MAX_WAIT≠0, the wait counter counts REQ cycles. When it equals MAX_WAIT-1 without ACK, withdraw to IDLE with pending unchanged. The counter is cleared on REQ entry.
  - ACK and withdraw in the same cycle: ACK wins.
- State COOL: count COOL_CYCLES cycles with INT_REQ=0, then go to IDLE. Pending bits keep updating during COOL.
- INT_ACK while in IDLE or COOL: ignored, no pending change.
- Reset asserted in any state, including mid-REQ: immediate return to the reset values on the next edge; pending bits are lost.
- Counters are 32-bit and do not wrap, because they are cleared on state entry.

Test Plan:
- Timer interrupt: MSTATUS_MIE=1, MIE=0x80; CLINT pulse code 7 at cycle 10 → MIP=0x80 at 11, INT_REQ=1 and INT_CAUSE=7 at 12. ACK at 14 → INT_REQ=0 at 15, MIP=0, COOL for 2 cycles, no re-request.
- Priority: MIE=0x888, pend_sw and pend_tm set, EXT_INT=1 → first INT_CAUSE=11. ACK and drop EXT_INT → after COOL, INT_CAUSE=3. ACK → INT_CAUSE=7.
- Software clear: pulse (EN=1, code 3) then (EN=0, code 3) with MSTATUS_MIE=0 → MIP bit 3 goes 1 then 0; INT_REQ never asserts.
- Masking withdraw: REQ with cause 7, then MSTATUS_MIE←0 → INT_REQ=0 next cycle, MIP still 0x80. Re-enable → REQ with cause 7 again.
- Timeout with MAX_WAIT=4: no ACK → INT_REQ high exactly 4 cycles, drops for 1 cycle, re-asserts with the same cause. ACK in IDLE has no effect.
- Simultaneous set and ACK: ACK of cause 7 in the same cycle as a new code-7 pulse → pend_tm stays 1 and the cause is re-requested after COOL. RST asserted mid-REQ → INT_REQ=0 and MIP=0 next cycle.
